// File: rtl/dsp_mac_pipe_if.sv
// Bundle of operand, control, handshake and result signals for one dsp_mac_pipe slice.
// master drives operands and out_ready; slave is the MAC slice itself.
`timescale 1ns/1ps
interface dsp_mac_pipe_if #(
  parameter int AW = 18,
  parameter int BW = 18,
  parameter int PW = 48
);
  logic [AW-1:0]    A;
  logic [BW-1:0]    B;
  logic [BW-1:0]    BCIN;
  logic [BW-1:0]    D;
  logic [PW-1:0]    C;
  logic [PW-1:0]    PCIN;
  logic [7:0]       opmode;
  logic             cin;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [PW-1:0]    P;
  logic [PW-1:0]    PCOUT;
  logic [BW-1:0]    BCOUT;
  logic [AW+BW-1:0] M;
  logic             CARRYOUT;
  logic             CARRYOUTF;
  logic             ovf;

  modport master (
    output A, B, BCIN, D, C, PCIN, opmode, cin, in_valid, out_ready,
    input  in_ready, out_valid, P, PCOUT, BCOUT, M, CARRYOUT, CARRYOUTF, ovf
  );

  modport slave (
    input  A, B, BCIN, D, C, PCIN, opmode, cin, in_valid, out_ready,
    output in_ready, out_valid, P, PCOUT, BCOUT, M, CARRYOUT, CARRYOUTF, ovf
  );
endinterface

// File: rtl/dsp_mac_pipe.sv
// Pipelined pre-adder / signed multiplier / post-adder MAC slice with valid/ready flow
// control, a global stall, opmode travelling with its data and optional saturation.
`timescale 1ns/1ps
module dsp_mac_pipe #(
  parameter int    AW        = 18,
  parameter int    BW        = 18,
  parameter int    PW        = 48,
  parameter int    PREADDREG = 1,
  parameter int    MREG      = 1,
  parameter string B_INPUT   = "DIRECT",
  parameter int    SAT_EN    = 0
) (
  input logic           clk,
  input logic           rstn,
  dsp_mac_pipe_if.slave bus
);

  typedef struct packed {
    logic          v;
    logic [7:0]    op;
    logic          ci;
    logic [PW-1:0] c;
    logic [PW-1:0] pcin;
  } ctl_t;

  ctl_t                ctl_in, ctl_pre, ctl_m;
  logic [AW-1:0]       a_in, a_pre;
  logic [BW-1:0]       b_in, d_in, bsel, pre_comb, pre_q;
  logic signed [AW+BW:0] prod;
  logic [AW+BW-1:0]    m_q;
  logic [PW-1:0]       m_ext, x, z, p_next, p_q;
  logic [PW:0]         sum;
  logic                ci, ovf_c, co_q, ovf_q, out_valid_q, en;
  logic                unused_op;

  // One enable for the whole pipe: everything advances unless a result is stuck in P.
  assign en           = ~(out_valid_q & ~bus.out_ready);
  assign bus.in_ready = en;
  assign bsel         = (B_INPUT == "CASCADE") ? bus.BCIN : bus.B;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctl_in <= '0;
      a_in   <= '0;
      b_in   <= '0;
      d_in   <= '0;
    end else if (en) begin
      ctl_in.v    <= bus.in_valid;
      ctl_in.op   <= bus.opmode;
      ctl_in.ci   <= bus.cin;
      ctl_in.c    <= bus.C;
      ctl_in.pcin <= bus.PCIN;
      a_in        <= bus.A;
      b_in        <= bsel;
      d_in        <= bus.D;
    end
  end

  always_comb begin
    pre_comb = b_in;
    if (ctl_in.op[4]) pre_comb = ctl_in.op[6] ? (d_in - b_in) : (d_in + b_in);
  end

  generate
    if (PREADDREG != 0) begin : g_prereg
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          ctl_pre <= '0;
          a_pre   <= '0;
          pre_q   <= '0;
        end else if (en) begin
          ctl_pre <= ctl_in;
          a_pre   <= a_in;
          pre_q   <= pre_comb;
        end
      end
    end else begin : g_nopre
      assign ctl_pre = ctl_in;
      assign a_pre   = a_in;
      assign pre_q   = pre_comb;
    end
  endgenerate

  // Pre-adder result is an unsigned magnitude: a zero MSB keeps it non-negative.
  assign prod = $signed(a_pre) * $signed({1'b0, pre_q});

  generate
    if (MREG != 0) begin : g_mreg
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          ctl_m <= '0;
          m_q   <= '0;
        end else if (en) begin
          ctl_m <= ctl_pre;
          m_q   <= prod[AW+BW-1:0];
        end
      end
    end else begin : g_nom
      assign ctl_m = ctl_pre;
      assign m_q   = prod[AW+BW-1:0];
    end
  endgenerate

  assign m_ext = {{(PW-AW-BW){m_q[AW+BW-1]}}, m_q};

  always_comb begin
    x      = '0;
    z      = '0;
    ci     = ctl_m.op[5] | ctl_m.ci;
    case (ctl_m.op[1:0])
      2'd0:    x = '0;
      2'd1:    x = m_ext;
      2'd2:    x = p_q;
      default: x = ctl_m.c;
    endcase
    case (ctl_m.op[3:2])
      2'd0:    z = '0;
      2'd1:    z = ctl_m.pcin;
      2'd2:    z = p_q;
      default: z = ctl_m.c;
    endcase
    if (ctl_m.op[7]) begin
      sum   = {1'b0, z} - {1'b0, x} - {{PW{1'b0}}, ci};
      ovf_c = (z[PW-1] != x[PW-1]) && (sum[PW-1] != z[PW-1]);
    end else begin
      sum   = {1'b0, z} + {1'b0, x} + {{PW{1'b0}}, ci};
      ovf_c = (z[PW-1] == x[PW-1]) && (sum[PW-1] != z[PW-1]);
    end
    p_next = sum[PW-1:0];
    // On overflow the true result always has the sign of Z.
    if ((SAT_EN != 0) && ovf_c)
      p_next = z[PW-1] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p_q         <= '0;
      co_q        <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (en) begin
      out_valid_q <= ctl_m.v;
      if (ctl_m.v) begin
        p_q   <= p_next;
        co_q  <= sum[PW];
        ovf_q <= ovf_c;
      end
    end
  end

  assign bus.P         = p_q;
  assign bus.PCOUT     = p_q;
  assign bus.BCOUT     = b_in;
  assign bus.M         = m_q;
  assign bus.CARRYOUT  = co_q;
  assign bus.CARRYOUTF = co_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = out_valid_q;

  assign unused_op = ^{ctl_m.op[6], ctl_m.op[4]};

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Bench for dsp_mac_pipe: a wrapping and a saturating slice share one stimulus stream;
// an arithmetic model fills a scoreboard at accept time and outputs are popped on transfer.
`timescale 1ns/1ps
module tb_dsp_mac_pipe;
  localparam int AW = 18;
  localparam int BW = 18;
  localparam int PW = 48;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic [BW-1:0] d;
    logic [PW-1:0] c;
    logic [PW-1:0] pcin;
    logic [7:0]    op;
    logic          cin;
  } beat_t;

  typedef struct packed {
    logic [PW-1:0] p;
    logic          co;
    logic          ovf;
  } res_t;

  typedef struct packed {
    res_t r0;
    res_t r1;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  int   checks;
  int   errors;
  beat_t tx_q[$];
  exp_t  sb_q[$];
  logic [PW-1:0] acc0, acc1;

  always #5 clk = ~clk;

  dsp_mac_pipe_if #(.AW(AW), .BW(BW), .PW(PW)) mif ();
  dsp_mac_pipe_if #(.AW(AW), .BW(BW), .PW(PW)) sif ();

  assign sif.A         = mif.A;
  assign sif.B         = mif.B;
  assign sif.BCIN      = mif.BCIN;
  assign sif.D         = mif.D;
  assign sif.C         = mif.C;
  assign sif.PCIN      = mif.PCIN;
  assign sif.opmode    = mif.opmode;
  assign sif.cin       = mif.cin;
  assign sif.in_valid  = mif.in_valid;
  assign sif.out_ready = mif.out_ready;

  dsp_mac_pipe #(.AW(AW), .BW(BW), .PW(PW), .SAT_EN(0)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (mif.slave)
  );

  dsp_mac_pipe #(.AW(AW), .BW(BW), .PW(PW), .SAT_EN(1)) dut_sat (
    .clk  (clk),
    .rstn (rstn),
    .bus  (sif.slave)
  );

  function automatic beat_t mk(input logic [AW-1:0] a, input logic [BW-1:0] b,
                               input logic [BW-1:0] d, input logic [PW-1:0] c,
                               input logic [PW-1:0] pcin, input logic [7:0] op,
                               input logic cin);
    beat_t bt;
    bt.a = a; bt.b = b; bt.d = d; bt.c = c; bt.pcin = pcin; bt.op = op; bt.cin = cin;
    return bt;
  endfunction

  // Reference arithmetic in 64-bit integers: exact result, then range check.
  function automatic res_t model(input beat_t bt, input logic [PW-1:0] pfb, input bit sat);
    res_t r;
    longint unsigned mask, pre, uz, ux;
    longint sa, prod, xs, zs, tot, maxv, minv;
    logic [AW+BW-1:0] mt;
    logic [PW-1:0] xm, x, z;
    logic ci;
    mask = (64'd1 << BW) - 64'd1;
    if (!bt.op[4])     pre = 64'(bt.b);
    else if (bt.op[6]) pre = (64'(bt.d) - 64'(bt.b)) & mask;
    else               pre = (64'(bt.d) + 64'(bt.b)) & mask;
    sa   = longint'($signed(bt.a));
    prod = sa * longint'(pre);
    mt   = prod[AW+BW-1:0];
    xm   = {{(PW-AW-BW){mt[AW+BW-1]}}, mt};
    case (bt.op[1:0])
      2'd0: x = '0;
      2'd1: x = xm;
      2'd2: x = pfb;
      default: x = bt.c;
    endcase
    case (bt.op[3:2])
      2'd0: z = '0;
      2'd1: z = bt.pcin;
      2'd2: z = pfb;
      default: z = bt.c;
    endcase
    ci   = bt.op[5] | bt.cin;
    zs   = longint'($signed(z));
    xs   = longint'($signed(x));
    uz   = 64'(z);
    ux   = 64'(x);
    maxv = (longint'(1) <<< (PW-1)) - 1;
    minv = -(longint'(1) <<< (PW-1));
    if (bt.op[7]) begin
      tot  = zs - xs - longint'(ci);
      r.co = (uz < (ux + 64'(ci)));
    end else begin
      tot  = zs + xs + longint'(ci);
      r.co = (((uz + ux + 64'(ci)) >> PW) != 64'd0);
    end
    r.ovf = (tot > maxv) || (tot < minv);
    if (sat && r.ovf) r.p = (tot > 0) ? maxv[PW-1:0] : minv[PW-1:0];
    else              r.p = tot[PW-1:0];
    return r;
  endfunction

  task automatic apply_reset();
    @(posedge clk); #2;
    rstn = 1'b0;
    mif.in_valid = 1'b0; mif.out_ready = 1'b1;
    tx_q.delete(); sb_q.delete();
    acc0 = '0; acc1 = '0;
    @(posedge clk); #2;
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  // Offers tx_q in order; a beat is scored at the edge where in_valid & in_ready.
  task automatic drive_beats();
    beat_t bt;
    exp_t  e;
    int    waitc;
    while (tx_q.size() > 0) begin
      bt = tx_q[0];
      mif.A = bt.a; mif.B = bt.b; mif.D = bt.d; mif.C = bt.c; mif.PCIN = bt.pcin;
      mif.opmode = bt.op; mif.cin = bt.cin; mif.in_valid = 1'b1;
      waitc = 0;
      @(negedge clk);
      while (!mif.in_ready && waitc < 100) begin @(negedge clk); waitc++; end
      if (!mif.in_ready) begin
        checks++; errors++;
        $display("FAIL drive_accept: in_ready=%0b after %0d cycles, required 1", mif.in_ready, waitc);
        tx_q.delete();
        mif.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      e.r0 = model(bt, acc0, 1'b0);
      e.r1 = model(bt, acc1, 1'b1);
      acc0 = e.r0.p; acc1 = e.r1.p;
      sb_q.push_back(e);
      bt = tx_q.pop_front();
      #1;
    end
    mif.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    int stale;
    apply_reset();
    for (int i = 0; i < 3; i++) tx_q.push_back(mk(18'd3, 18'd7, 18'd0, '0, '0, 8'h01, 1'b0));
    drive_beats();
    @(posedge clk); #1;
    e = (sb_q.size() > 0) ? sb_q[0] : '0;
    checks++;
    if (mif.out_valid !== 1'b1 || mif.P !== 48'd21 || mif.P !== e.r0.p) begin
      errors++;
      $display("FAIL reset_preload: out_valid=%0b P=%h, required 1 P=%h", mif.out_valid, mif.P, 48'd21);
    end
    #1 rstn = 1'b0;
    #1;
    checks++;
    if (mif.P !== '0 || mif.M !== '0 || mif.BCOUT !== '0 || mif.out_valid !== 1'b0 ||
        mif.in_ready !== 1'b1 || mif.CARRYOUT !== 1'b0 || mif.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: P=%h M=%h BCOUT=%h ov=%0b ir=%0b co=%0b ovf=%0b, required zeros with in_ready=1",
               mif.P, mif.M, mif.BCOUT, mif.out_valid, mif.in_ready, mif.CARRYOUT, mif.ovf);
    end
    checks++;
    if (sif.P !== '0 || sif.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_sat: P=%h out_valid=%0b, required 0 0", sif.P, sif.out_valid);
    end
    sb_q.delete(); acc0 = '0; acc1 = '0;
    #3 rstn = 1'b1;
    stale = 0;
    repeat (10) begin @(posedge clk); #1; if (mif.out_valid) stale++; end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL reset_stale: %0d stale outputs, required 0", stale);
    end
  endtask

  task automatic test_preadd();
    exp_t e;
    int lat, got;
    apply_reset();
    tx_q.push_back(mk(18'd4, 18'd3, 18'd5, '0, '0, 8'h11, 1'b0));
    drive_beats();
    checks++;
    if (mif.BCOUT !== 18'd3) begin
      errors++; $display("FAIL bcout: BCOUT=%h, required %h", mif.BCOUT, 18'd3);
    end
    lat = 1;
    while (!mif.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat != 4) begin errors++; $display("FAIL latency: %0d cycles, required 4", lat); end
    checks++;
    if (mif.P !== 48'd32 || mif.CARRYOUT !== 1'b0 || mif.ovf !== 1'b0) begin
      errors++;
      $display("FAIL preadd_sum: P=%h co=%0b ovf=%0b, required %h 0 0", mif.P, mif.CARRYOUT, mif.ovf, 48'd32);
    end
    e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    checks++;
    if (sif.P !== e.r1.p) begin
      errors++; $display("FAIL preadd_sat: P=%h, required %h", sif.P, e.r1.p);
    end
    tx_q.push_back(mk(18'd5, 18'd3, 18'd5, '0, '0, 8'h51, 1'b0));          // D-B
    tx_q.push_back(mk(18'd1, 18'd1, 18'd0, '0, '0, 8'h51, 1'b0));          // D-B wraps
    tx_q.push_back(mk(18'h3FFFD, 18'd5, 18'd0, '0, '0, 8'h01, 1'b0));      // negative A
    tx_q.push_back(mk(18'h3FFFF, 18'd1, 18'h3FFFF, '0, '0, 8'h11, 1'b0));  // D+B wraps to 0
    tx_q.push_back(mk(18'd3, 18'h3FFFF, 18'd0, '0, '0, 8'h01, 1'b0));      // B is unsigned
    got = 0;
    fork
      drive_beats();
      for (int cyc = 0; cyc < 100 && got < 5; cyc++) begin
        @(posedge clk); #1;
        if (mif.out_valid && mif.out_ready) begin
          e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
          got++;
          checks++;
          if (mif.P !== e.r0.p || mif.CARRYOUT !== e.r0.co || mif.ovf !== e.r0.ovf ||
              sif.P !== e.r1.p || sif.ovf !== e.r1.ovf) begin
            errors++;
            $display("FAIL preadd_beat%0d: P=%h co=%0b ovf=%0b satP=%h, required %h %0b %0b %h",
                     got, mif.P, mif.CARRYOUT, mif.ovf, sif.P, e.r0.p, e.r0.co, e.r0.ovf, e.r1.p);
          end
        end
      end
    join
    checks++;
    if (got != 5) begin errors++; $display("FAIL preadd_count: %0d results, required 5", got); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int got, first, last;
    apply_reset();
    for (int i = 0; i < 4; i++) tx_q.push_back(mk(18'd2, 18'd3, 18'd0, '0, '0, 8'h09, 1'b0));
    got = 0; first = 0; last = 0;
    fork
      drive_beats();
      for (int cyc = 0; cyc < 100 && got < 4; cyc++) begin
        @(posedge clk); #1;
        if (mif.out_valid && mif.out_ready) begin
          e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
          if (got == 0) first = cyc;
          last = cyc;
          got++;
          checks++;
          if (mif.P !== e.r0.p || mif.P !== 48'(6 * got) || sif.P !== e.r1.p) begin
            errors++;
            $display("FAIL b2b_acc%0d: P=%h satP=%h, required %h", got, mif.P, sif.P, 48'(6 * got));
          end
        end
      end
    join
    checks++;
    if (got != 4 || last - first != 3) begin
      errors++; $display("FAIL b2b_spacing: %0d results over %0d cycles, required 4 over 3", got, last - first);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    int got;
    bit stalled;
    apply_reset();
    for (int i = 0; i < 6; i++) tx_q.push_back(mk(18'd2, 18'd3, 18'd0, '0, '0, 8'h09, 1'b0));
    got = 0; stalled = 1'b0;
    fork
      drive_beats();
      for (int cyc = 0; cyc < 100 && got < 6; cyc++) begin
        @(posedge clk); #1;
        if (mif.out_valid && !stalled) begin
          stalled = 1'b1;
          mif.out_ready = 1'b0;
          repeat (5) begin
            @(posedge clk); #1;
            checks++;
            if (mif.in_ready !== 1'b0 || mif.out_valid !== 1'b1 || mif.P !== 48'd6) begin
              errors++;
              $display("FAIL stall_hold: in_ready=%0b out_valid=%0b P=%h, required 0 1 %h",
                       mif.in_ready, mif.out_valid, mif.P, 48'd6);
            end
          end
          mif.out_ready = 1'b1;
        end
        if (mif.out_valid && mif.out_ready) begin
          e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
          got++;
          checks++;
          if (mif.P !== e.r0.p || mif.P !== 48'(6 * got) || sif.P !== e.r1.p) begin
            errors++;
            $display("FAIL stall_acc%0d: P=%h satP=%h, required %h", got, mif.P, sif.P, 48'(6 * got));
          end
        end
      end
    join
    checks++;
    if (got != 6 || sb_q.size() != 0) begin
      errors++; $display("FAIL stall_count: %0d results, %0d pending, required 6 and 0", got, sb_q.size());
    end
  endtask

  task automatic test_sub_mux();
    exp_t e;
    int got;
    apply_reset();
    tx_q.push_back(mk(18'd1, 18'd1, 18'd0, 48'd0,  '0,      8'h8D, 1'b0));  // 0 - 1
    tx_q.push_back(mk(18'd1, 18'd1, 18'd0, 48'd5,  '0,      8'h8D, 1'b0));  // 5 - 1
    tx_q.push_back(mk(18'd1, 18'd1, 18'd0, 48'd10, '0,      8'h0D, 1'b1));  // cin pin
    tx_q.push_back(mk(18'd1, 18'd1, 18'd0, 48'd10, '0,      8'h2D, 1'b0));  // opmode[5]
    tx_q.push_back(mk(18'd0, 18'd0, 18'd0, 48'd0,  48'd100, 8'h06, 1'b0));  // P + PCIN
    tx_q.push_back(mk(18'd0, 18'd0, 18'd0, 48'd10, '0,      8'h0E, 1'b0));  // C + P
    tx_q.push_back(mk(18'd0, 18'd0, 18'd0, 48'd7,  '0,      8'h8E, 1'b1));  // C - (P + 1)
    tx_q.push_back(mk(18'd9, 18'd9, 18'd0, 48'd7,  48'd3,   8'h00, 1'b0));  // zero
    got = 0;
    fork
      drive_beats();
      for (int cyc = 0; cyc < 120 && got < 8; cyc++) begin
        @(posedge clk); #1;
        if (mif.out_valid && mif.out_ready) begin
          e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
          got++;
          if (got == 1) begin
            checks++;
            if (mif.P !== 48'hFFFF_FFFF_FFFF || mif.CARRYOUT !== 1'b1 || mif.CARRYOUTF !== 1'b1 ||
                mif.ovf !== 1'b0) begin
              errors++;
              $display("FAIL sub_borrow: P=%h co=%0b cof=%0b ovf=%0b, required ffffffffffff 1 1 0",
                       mif.P, mif.CARRYOUT, mif.CARRYOUTF, mif.ovf);
            end
          end
          checks++;
          if (mif.P !== e.r0.p || mif.PCOUT !== e.r0.p || mif.CARRYOUT !== e.r0.co ||
              mif.ovf !== e.r0.ovf || sif.P !== e.r1.p || sif.ovf !== e.r1.ovf) begin
            errors++;
            $display("FAIL mux_beat%0d: P=%h co=%0b ovf=%0b satP=%h, required %h %0b %0b %h",
                     got, mif.P, mif.CARRYOUT, mif.ovf, sif.P, e.r0.p, e.r0.co, e.r0.ovf, e.r1.p);
          end
        end
      end
    join
    checks++;
    if (got != 8) begin errors++; $display("FAIL mux_count: %0d results, required 8", got); end
  endtask

  task automatic test_saturate();
    exp_t e;
    int got;
    apply_reset();
    tx_q.push_back(mk(18'd1, 18'd1, 18'd0, 48'h7FFF_FFFF_FFFF, '0, 8'h0D, 1'b0));
    tx_q.push_back(mk(18'd1, 18'd1, 18'd0, 48'h8000_0000_0000, '0, 8'h8D, 1'b0));
    tx_q.push_back(mk(18'd1, 18'd1, 18'd0, 48'h7FFF_FFFF_FFFE, '0, 8'h0D, 1'b0));
    got = 0;
    fork
      drive_beats();
      for (int cyc = 0; cyc < 100 && got < 3; cyc++) begin
        @(posedge clk); #1;
        if (mif.out_valid && mif.out_ready) begin
          e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
          got++;
          if (got == 1) begin
            checks++;
            if (sif.P !== 48'h7FFF_FFFF_FFFF || sif.ovf !== 1'b1) begin
              errors++;
              $display("FAIL sat_pos: P=%h ovf=%0b, required 7fffffffffff 1", sif.P, sif.ovf);
            end
            checks++;
            if (mif.P !== 48'h8000_0000_0000 || mif.ovf !== 1'b1) begin
              errors++;
              $display("FAIL wrap_pos: P=%h ovf=%0b, required 800000000000 1", mif.P, mif.ovf);
            end
          end
          checks++;
          if (mif.P !== e.r0.p || mif.CARRYOUT !== e.r0.co || mif.ovf !== e.r0.ovf ||
              sif.P !== e.r1.p || sif.CARRYOUT !== e.r1.co || sif.ovf !== e.r1.ovf) begin
            errors++;
            $display("FAIL sat_beat%0d: P=%h ovf=%0b satP=%h satovf=%0b, required %h %0b %h %0b",
                     got, mif.P, mif.ovf, sif.P, sif.ovf, e.r0.p, e.r0.ovf, e.r1.p, e.r1.ovf);
          end
        end
      end
    join
    checks++;
    if (got != 3) begin errors++; $display("FAIL sat_count: %0d results, required 3", got); end
  endtask

  initial begin
    checks = 0; errors = 0;
    acc0 = '0; acc1 = '0;
    rstn = 1'b0;
    mif.A = '0; mif.B = '0; mif.BCIN = '0; mif.D = '0; mif.C = '0; mif.PCIN = '0;
    mif.opmode = '0; mif.cin = 1'b0; mif.in_valid = 1'b0; mif.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    test_reset();
    test_preadd();
    test_back_to_back();
    test_stall();
    test_sub_mux();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog timeout");
  end

endmodule

// File: doc/dsp_mac_pipe.md
Name: dsp_mac_pipe

Overview:
Parametrised successor to the DSP48A1 slice: pre-adder, signed multiplier and post-adder/accumulator, with generic operand widths and a configurable pipeline depth. It adds a valid/ready handshake with global stall, an opmode word that travels with its data through the pipeline, and optional saturating overflow. It sits in the datapath as a cascadable MAC element (BCOUT/PCOUT feed the next slice).

Parameters:
AW, 18, width of A
BW, 18, width of B, D and BCOUT (pre-adder width)
PW, 48, width of C, PCIN, P and PCOUT; must be >= AW+BW+1
PREADDREG, 1, 0/1: register after the pre-adder
MREG, 1, 0/1: register after the multiplier
B_INPUT, "DIRECT", "DIRECT" selects B; "CASCADE" selects BCIN
SAT_EN, 0, 1 = clamp signed overflow of the post-adder

Ports:
clk  in  1  clock, rising edge
rstn  in  1  async active-low reset
A  in  AW  multiplier operand, signed
B  in  BW  pre-adder operand
BCIN  in  BW  cascade B input
D  in  BW  pre-adder operand
C  in  PW  post-adder operand
PCIN  in  PW  cascade P input
opmode  in  8  operation select, sampled with data
cin  in  1  carry-in, sampled with data
in_valid  in  1  input beat valid
in_ready  out  1  input accepted when in_valid&in_ready
out_valid  out  1  P holds a result
out_ready  in  1  consumer ready
P  out  PW  result register
PCOUT  out  PW  copy of P
BCOUT  out  BW  registered B-path value (input stage)
M  out  AW+BW  product at M stage
CARRYOUT  out  1  post-adder carry/borrow
CARRYOUTF  out  1  copy of CARRYOUT
ovf  out  1  signed overflow flag of the current P

Behaviour:
- Reset (rstn=0, async, overrides all): every pipeline register, valid bit, P, M, CARRYOUT, ovf = 0; out_valid=0; in_ready=1 after reset.
- Stages: IN reg (always) -> [PRE reg if PREADDREG] -> [M reg if MREG] -> P reg (always). Latency LAT = 2+PREADDREG+MREG cycles from accept to out_valid.
- Global enable en = ~(out_valid & ~out_ready); in_ready = en. When en=0, all stages hold, including P and opmode/cin pipelines. When en=1, every stage advances, bubbles included.
- Each stage carries a valid bit. P, CARRYOUT and ovf update only when the beat entering the P stage is valid; otherwise they hold while out_valid falls to 0 (if out_ready).
- Pre-adder: opmode[4]=0 -> pre=Bsel; opmode[4]=1 -> pre = opmode[6] ? D-Bsel : D+Bsel, BW bits, wraps modulo 2^BW, treated as unsigned BW-bit value zero-extended to the multiplier.
- Multiplier: M = signed(A) * signed({1'b0,pre}), truncated to AW+BW bits, two's complement; sign-extended to PW for the post-adder.
- X mux opmode[1:0]: 0 zero, 1 M, 2 P, 3 C. Z mux opmode[3:2]: 0 zero, 1 PCIN, 2 P, 3 C.
- Carry-in = opmode[5] (CARRYINSEL fixed "OPMODE5") OR cin.
- Post-adder in PW+1 bits: opmode[7]=0 -> {co,s}=Z+X+ci; opmode[7]=1 -> {co,s}=Z-(X+ci) (co=1 indicates borrow). CARRYOUT=co.
- Overflow: signed overflow of s relative to sign(Z) and sign(X) -> ovf=1. With SAT_EN=1, P = 2^(PW-1)-1 on positive overflow and -2^(PW-1) on negative overflow; CARRYOUT stays raw. With SAT_EN=0, P=s and ovf is still reported.
- P feedback uses the P register value at the moment the beat enters the P stage, so back-to-back accumulation is exact.
- Simultaneous accept and stall: no input is accepted while in_ready=0. No beat is dropped or duplicated.

Test Plan (defaults, LAT=4):
1. Pulse rstn low while 3 beats are in flight -> P=0, M=0, out_valid=0, in_ready=1 immediately; no stale beat ever appears afterwards.
2. A=4, D=5, B=3, opmode=8'h11, cin=0 -> out_valid on cycle 4, P=32, CARRYOUT=0.
3. Four back-to-back beats A=2, B=3, opmode=8'h09 (X=M, Z=P), out_ready=1 -> P=6, 12, 18, 24 on consecutive cycles.
4. Same stream with out_ready=0 for 5 cycles after the first result -> in_ready=0 and P held at 6; after release, P=12, 18, 24 with no loss.
5. C=0, M=1 (A=1, B=1), opmode=8'h8D (sub, Z=C, X=M) -> P=48'hFFFF_FFFF_FFFF, CARRYOUT=1, ovf=0.
6. SAT_EN=1, C=2^47-1, A=1, B=1, opmode=8'h0D -> P=2^47-1, ovf=1; repeat with SAT_EN=0 -> P=48'h8000_0000_0000, ovf=1.
